fgen_eval_sched: RTL and testbench



---
 rtl/fgen_eval_sched.sv | 171 +++++++++++++++++
 tb/tb_fgen_eval_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fgen_eval_sched.sv
// fgen_eval_sched
// Shares one combinational 4-in/NOUT-out function block between two
// requesters. It also runs a self-test sweep over all 16 input codes and
// folds the results into an NOUT-bit signature.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   req0_i/req1_i            level requests, held high until granted
//   code0_i/code1_i          {w,x,y,z} code for each requester
//   gnt0_o/gnt1_o            one-cycle grant pulses
//   res0_o/res1_o            last captured result per requester
//   vld0_o/vld1_o            one-cycle result-valid pulses
//   sweep_start_i            starts a self-test sweep (honoured in IDLE only)
//   sweep_busy_o             sweep in progress
//   sweep_done_o             one-cycle pulse when the sweep completes
//   sweep_sig_o              sweep signature, held until the next sweep
//   wxyz_o                   registered drive into the function block
//   f_i                      function block outputs
//   busy_o                   scheduler is not in IDLE
module fgen_eval_sched #(
    parameter int SETTLE = 2,
    parameter int NOUT   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_i,
    input  logic [3:0]      code0_i,
    output logic            gnt0_o,
    output logic [NOUT-1:0] res0_o,
    output logic            vld0_o,
    input  logic            req1_i,
    input  logic [3:0]      code1_i,
    output logic            gnt1_o,
    output logic [NOUT-1:0] res1_o,
    output logic            vld1_o,
    input  logic            sweep_start_i,
    output logic            sweep_busy_o,
    output logic            sweep_done_o,
    output logic [NOUT-1:0] sweep_sig_o,
    output logic [3:0]      wxyz_o,
    input  logic [NOUT-1:0] f_i,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        SWP_WAIT = 2'd2
    } state_t;

    // Settle counter value on the capture edge.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t          state_q;
    logic            ptr_q;
    logic            owner_q;
    logic [3:0]      cnt_q;
    logic [3:0]      idx_q;
    logic [3:0]      wxyz_q;
    logic            gnt0_q;
    logic            gnt1_q;
    logic            vld0_q;
    logic            vld1_q;
    logic [NOUT-1:0] res0_q;
    logic [NOUT-1:0] res1_q;
    logic            sweep_busy_q;
    logic            sweep_done_q;
    logic [NOUT-1:0] sweep_sig_q;

    // Next signature value: rotate left by one, then fold in the new result.
    logic [NOUT-1:0] sig_d;
    assign sig_d = {sweep_sig_q[NOUT-2:0], sweep_sig_q[NOUT-1]} ^ f_i;

    // ptr_q set means requester 1 wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            wxyz_q       <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            vld0_q       <= 1'b0;
            vld1_q       <= 1'b0;
            res0_q       <= '0;
            res1_q       <= '0;
            sweep_busy_q <= 1'b0;
            sweep_done_q <= 1'b0;
            sweep_sig_q  <= '0;
        end else begin
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            vld0_q       <= 1'b0;
            vld1_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sweep_start_i) begin
                        sweep_sig_q  <= '0;
                        idx_q        <= '0;
                        wxyz_q       <= '0;
                        sweep_busy_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= SWP_WAIT;
                    end else if (req0_i && (!req1_i || !ptr_q)) begin
                        gnt0_q  <= 1'b1;
                        wxyz_q  <= code0_i;
                        owner_q <= 1'b0;
                        ptr_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end else if (req1_i) begin
                        gnt1_q  <= 1'b1;
                        wxyz_q  <= code1_i;
                        owner_q <= 1'b1;
                        ptr_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        if (owner_q) begin
                            res1_q <= f_i;
                            vld1_q <= 1'b1;
                        end else begin
                            res0_q <= f_i;
                            vld0_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                SWP_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        sweep_sig_q <= sig_d;
                        // Code 15 is the last one; the sweep never wraps on its own.
                        if (idx_q == 4'hF) begin
                            sweep_done_q <= 1'b1;
                            sweep_busy_q <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            idx_q  <= idx_q + 4'd1;
                            wxyz_q <= idx_q + 4'd1;
                            cnt_q  <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0_o       = gnt0_q;
    assign gnt1_o       = gnt1_q;
    assign vld0_o       = vld0_q;
    assign vld1_o       = vld1_q;
    assign res0_o       = res0_q;
    assign res1_o       = res1_q;
    assign wxyz_o       = wxyz_q;
    assign sweep_busy_o = sweep_busy_q;
    assign sweep_done_o = sweep_done_q;
    assign sweep_sig_o  = sweep_sig_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_fgen_eval_sched.sv
// tb_fgen_eval_sched
// Directed bench for fgen_eval_sched. The main instance uses SETTLE=2 and a
// selectable function-block stub; a second instance uses SETTLE=1 to cover
// the fastest back-to-back case.
module tb_fgen_eval_sched;

    logic clk = 1'b0;

    // Main instance (SETTLE = 2) signals
    logic       rstN;
    logic       req0, req1, sweepStart;
    logic [3:0] code0, code1;
    logic       gnt0, gnt1, vld0, vld1, sweepBusy, sweepDone, busy;
    logic [9:0] res0, res1, sweepSig, fOut;
    logic [3:0] wxyz;
    logic [1:0] stubMode;

    // SETTLE = 1 instance signals
    logic       s1RstN;
    logic       s1Req1;
    logic [3:0] s1Code1;
    logic       s1Gnt0, s1Gnt1, s1Vld0, s1Vld1, s1SweepBusy, s1SweepDone, s1Busy;
    logic [9:0] s1Res0, s1Res1, s1SweepSig, s1F;
    logic [3:0] s1Wxyz;

    int checks = 0;
    int errors = 0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Function block stubs: mode 0 = {~code, 01, code}, mode 1 = all ones at
    // code 5 only, mode 2 = single LSB at code 0 only.
    always_comb begin
        fOut = 10'h000;
        case (stubMode)
            2'd0: fOut = {~wxyz, 2'b01, wxyz};
            2'd1: fOut = (wxyz == 4'h5) ? 10'h3FF : 10'h000;
            2'd2: fOut = (wxyz == 4'h0) ? 10'h001 : 10'h000;
            default: fOut = 10'h000;
        endcase
    end

    assign s1F = {~s1Wxyz, 2'b01, s1Wxyz};

    fgen_eval_sched #(.SETTLE(2), .NOUT(10)) dut (
        .clk(clk), .rst_n(rstN),
        .req0_i(req0), .code0_i(code0), .gnt0_o(gnt0), .res0_o(res0), .vld0_o(vld0),
        .req1_i(req1), .code1_i(code1), .gnt1_o(gnt1), .res1_o(res1), .vld1_o(vld1),
        .sweep_start_i(sweepStart), .sweep_busy_o(sweepBusy), .sweep_done_o(sweepDone),
        .sweep_sig_o(sweepSig), .wxyz_o(wxyz), .f_i(fOut), .busy_o(busy)
    );

    fgen_eval_sched #(.SETTLE(1), .NOUT(10)) dutS1 (
        .clk(clk), .rst_n(s1RstN),
        .req0_i(1'b0), .code0_i(4'h0), .gnt0_o(s1Gnt0), .res0_o(s1Res0), .vld0_o(s1Vld0),
        .req1_i(s1Req1), .code1_i(s1Code1), .gnt1_o(s1Gnt1), .res1_o(s1Res1), .vld1_o(s1Vld1),
        .sweep_start_i(1'b0), .sweep_busy_o(s1SweepBusy), .sweep_done_o(s1SweepDone),
        .sweep_sig_o(s1SweepSig), .wxyz_o(s1Wxyz), .f_i(s1F), .busy_o(s1Busy)
    );

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset the main instance with all requester inputs idle.
    task automatic applyStimulus;
        rstN       = 1'b0;
        req0       = 1'b0;
        req1       = 1'b0;
        code0      = 4'h0;
        code1      = 4'h0;
        sweepStart = 1'b0;
        stubMode   = 2'd0;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    // All outputs must be zero while held in reset, and stay idle afterwards.
    task automatic test_reset;
        applyStimulus();
        rstN = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, vld0, vld1, sweepBusy, sweepDone, busy, wxyz} !== 11'h0) begin
            $display("[TB] FAIL reset_ctrl got %h want 0", {gnt0, gnt1, vld0, vld1, sweepBusy, sweepDone, busy, wxyz});
            errors++;
        end
        checks++;
        if ({res0, res1, sweepSig} !== 30'h0) begin
            $display("[TB] FAIL reset_data got %h want 0", {res0, res1, sweepSig});
            errors++;
        end
        rstN = 1'b1;
        tick();
        checks++;
        if ({busy, gnt0, gnt1} !== 3'b000) begin
            $display("[TB] FAIL reset_idle got %b want 000", {busy, gnt0, gnt1});
            errors++;
        end
    endtask

    // One request from requester 0: grant, settle, capture.
    task automatic test_single_request;
        applyStimulus();
        req0  = 1'b1;
        code0 = 4'h5;
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1, wxyz, busy, vld0} !== {1'b1, 1'b0, 4'h5, 1'b1, 1'b0}) begin
            $display("[TB] FAIL single_grant got gnt0=%b gnt1=%b wxyz=%h busy=%b vld0=%b want 1 0 5 1 0", gnt0, gnt1, wxyz, busy, vld0);
            errors++;
        end
        tick();
        checks++;
        if ({gnt0, busy, vld0} !== 3'b010) begin
            $display("[TB] FAIL single_settle got gnt0/busy/vld0=%b want 010", {gnt0, busy, vld0});
            errors++;
        end
        tick();
        checks++;
        if ({vld0, vld1, busy} !== 3'b100 || res0 !== 10'h295) begin
            $display("[TB] FAIL single_capture got vld0/vld1/busy=%b res0=%h want 100 295", {vld0, vld1, busy}, res0);
            errors++;
        end
        tick();
        checks++;
        if (vld0 !== 1'b0 || res0 !== 10'h295 || wxyz !== 4'h5) begin
            $display("[TB] FAIL single_hold got vld0=%b res0=%h wxyz=%h want 0 295 5", vld0, res0, wxyz);
            errors++;
        end
    endtask

    // Both requests held from reset: round robin 0, 1, 0, three cycles apart.
    task automatic test_back_to_back;
        applyStimulus();
        rstN  = 1'b0;
        req0  = 1'b1;
        code0 = 4'h3;
        req1  = 1'b1;
        code1 = 4'hC;
        tick();
        rstN = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            $display("[TB] FAIL b2b_first got gnt0/gnt1=%b want 10", {gnt0, gnt1});
            errors++;
        end
        tick();
        tick();
        checks++;
        if ({vld0, gnt1} !== 2'b10 || res0 !== 10'h313) begin
            $display("[TB] FAIL b2b_res0 got vld0/gnt1=%b res0=%h want 10 313", {vld0, gnt1}, res0);
            errors++;
        end
        tick();
        checks++;
        if ({gnt0, gnt1, wxyz} !== {2'b01, 4'hC}) begin
            $display("[TB] FAIL b2b_second got gnt0/gnt1=%b wxyz=%h want 01 c", {gnt0, gnt1}, wxyz);
            errors++;
        end
        tick();
        tick();
        checks++;
        if (vld1 !== 1'b1 || res1 !== 10'h0DC) begin
            $display("[TB] FAIL b2b_res1 got vld1=%b res1=%h want 1 0dc", vld1, res1);
            errors++;
        end
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            $display("[TB] FAIL b2b_third got gnt0/gnt1=%b want 10", {gnt0, gnt1});
            errors++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Full sweep with a given stub; a sweep_start pulse mid-sweep is ignored.
    task automatic test_sweep_signature(input logic [1:0] mode, input logic [9:0] expSig);
        logic [3:0] expW;
        applyStimulus();
        stubMode   = mode;
        sweepStart = 1'b1;
        tick();
        checks++;
        if ({sweepBusy, busy, wxyz, sweepDone} !== {2'b11, 4'h0, 1'b0}) begin
            $display("[TB] FAIL sweep_start got busy=%b/%b wxyz=%h done=%b want 1/1 0 0", sweepBusy, busy, wxyz, sweepDone);
            errors++;
        end
        for (int k = 1; k <= 32; k++) begin
            sweepStart = (k == 10);
            tick();
            expW = ((k / 2) > 15) ? 4'hF : 4'(k / 2);
            checks++;
            if ({wxyz, sweepDone, sweepBusy} !== {expW, (k == 32), (k < 32)}) begin
                $display("[TB] FAIL sweep_step k=%0d got wxyz=%h done=%b busy=%b want %h %b %b", k, wxyz, sweepDone, sweepBusy, expW, (k == 32), (k < 32));
                errors++;
            end
        end
        sweepStart = 1'b0;
        checks++;
        if (sweepSig !== expSig) begin
            $display("[TB] FAIL sweep_sig mode=%0d got %h want %h", mode, sweepSig, expSig);
            errors++;
        end
        tick();
        checks++;
        if ({sweepDone, sweepBusy, busy} !== 3'b000 || sweepSig !== expSig) begin
            $display("[TB] FAIL sweep_after got done/busy/busy=%b sig=%h want 000 %h", {sweepDone, sweepBusy, busy}, sweepSig, expSig);
            errors++;
        end
    endtask

    // Sweep and request in the same IDLE cycle: sweep first, then the grant.
    task automatic test_sweep_and_request;
        bit doneSeen;
        bit earlyGnt;
        applyStimulus();
        sweepStart = 1'b1;
        req1       = 1'b1;
        code1      = 4'h9;
        tick();
        sweepStart = 1'b0;
        checks++;
        if ({sweepBusy, gnt1} !== 2'b10) begin
            $display("[TB] FAIL mix_start got sweepBusy/gnt1=%b want 10", {sweepBusy, gnt1});
            errors++;
        end
        doneSeen = 1'b0;
        earlyGnt = 1'b0;
        for (int k = 0; k < 40 && !doneSeen; k++) begin
            tick();
            if (gnt1) earlyGnt = 1'b1;
            if (sweepDone) doneSeen = 1'b1;
        end
        checks++;
        if (!doneSeen || earlyGnt) begin
            $display("[TB] FAIL mix_sweep got done=%b earlyGnt=%b want 1 0", doneSeen, earlyGnt);
            errors++;
        end
        tick();
        checks++;
        if ({gnt1, wxyz} !== {1'b1, 4'h9}) begin
            $display("[TB] FAIL mix_grant got gnt1=%b wxyz=%h want 1 9", gnt1, wxyz);
            errors++;
        end
        req1 = 1'b0;
        tick();
        tick();
        checks++;
        if (vld1 !== 1'b1 || res1 !== 10'h199) begin
            $display("[TB] FAIL mix_res1 got vld1=%b res1=%h want 1 199", vld1, res1);
            errors++;
        end
    endtask

    // Reset during a sweep clears everything at once and leaves no pulse behind.
    task automatic test_reset_mid_sweep;
        bit stray;
        applyStimulus();
        stubMode = 2'd1;
        req0     = 1'b1;
        code0    = 4'h5;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        checks++;
        if (res0 !== 10'h3FF) begin
            $display("[TB] FAIL abort_pre_res0 got %h want 3ff", res0);
            errors++;
        end
        sweepStart = 1'b1;
        tick();
        sweepStart = 1'b0;
        repeat (14) tick();
        checks++;
        if (wxyz !== 4'h7 || sweepSig !== 10'h3FF) begin
            $display("[TB] FAIL abort_idx7 got wxyz=%h sig=%h want 7 3ff", wxyz, sweepSig);
            errors++;
        end
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, vld0, vld1, sweepBusy, sweepDone, busy, wxyz, res0, res1, sweepSig} !== 41'h0) begin
            $display("[TB] FAIL abort_async got sig=%h res0=%h wxyz=%h busy=%b sweepBusy=%b want all 0", sweepSig, res0, wxyz, busy, sweepBusy);
            errors++;
        end
        tick();
        tick();
        rstN     = 1'b1;
        stray    = 1'b0;
        stubMode = 2'd0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (sweepDone || sweepBusy || busy) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            $display("[TB] FAIL abort_quiet got activity=%b want 0", stray);
            errors++;
        end
        req0  = 1'b1;
        code0 = 4'h3;
        req1  = 1'b1;
        code1 = 4'hC;
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            $display("[TB] FAIL abort_ptr got gnt0/gnt1=%b want 10", {gnt0, gnt1});
            errors++;
        end
        tick();
        tick();
        checks++;
        if (vld0 !== 1'b1 || res0 !== 10'h313) begin
            $display("[TB] FAIL abort_serve got vld0=%b res0=%h want 1 313", vld0, res0);
            errors++;
        end
        tick();
    endtask

    // SETTLE=1: req1 held high gives a grant every 2 cycles, result 1 cycle later.
    task automatic test_settle1;
        s1Req1  = 1'b1;
        s1Code1 = 4'hA;
        s1RstN  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if ({s1Gnt1, s1Vld1} !== {(k % 2 == 1), (k % 2 == 0)}) begin
                $display("[TB] FAIL settle1_seq k=%0d got gnt1=%b vld1=%b want %b %b", k, s1Gnt1, s1Vld1, (k % 2 == 1), (k % 2 == 0));
                errors++;
            end
            if (k % 2 == 0) begin
                checks++;
                if (s1Res1 !== 10'h15A) begin
                    $display("[TB] FAIL settle1_res k=%0d got %h want 15a", k, s1Res1);
                    errors++;
                end
            end
        end
        s1Req1 = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        s1RstN  = 1'b0;
        s1Req1  = 1'b0;
        s1Code1 = 4'h0;
        test_reset();
        test_single_request();
        test_back_to_back();
        test_sweep_signature(2'd1, 10'h3FF);
        test_sweep_signature(2'd2, 10'h020);
        test_sweep_and_request();
        test_reset_mid_sweep();
        test_settle1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
